// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressed data memory: access size codes,
// controller states and the byte count of each access size.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {CLEAR, RUN} state_t;

  // The illegal code maps to 4 so the range check stays well defined.
  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: bytes_of = 3'd1;
      SZ_HALF: bytes_of = 3'd2;
      default: bytes_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_extend.sv
// Load formatter: picks the addressed byte or half-word out of a 32-bit word
// and sign- or zero-extends it. Purely combinational, no flow control.
module dmem_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        unsgn,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: result = {{24{~unsgn & b[7]}}, b};
      SZ_HALF: result = {{16{~unsgn & h[15]}}, h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with self-clearing sweep.
// Latency: loads return 1 cycle after acceptance; stores complete on the accept edge.
// Backpressure: ready drops during a clear sweep and in the cycle clear is seen.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              req,
  input  logic              wren,
  input  logic [1:0]        size,
  input  logic              unsgn,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] datain,
  output logic              ready,
  output logic              rdvalid,
  output logic [DATA_W-1:0] dataout,
  output logic              err,
  output logic              busy
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            accept, bad, misalign, range_err;
  logic [2:0]      nbytes;
  logic [1:0]      off;
  logic [IW-1:0]   aidx, widx;
  logic [31:0]     rword, ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      CLEAR: begin
        busy  = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(WORDS - 1)) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      default: begin
        // clear takes priority over any request presented in the same cycle
        if (clear) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else begin
          ready = 1'b1;
        end
      end
    endcase
  end

  assign accept    = req & ready;
  assign nbytes    = bytes_of(size);
  assign off       = adr[1:0];
  assign aidx      = adr[IW+1:2];
  assign misalign  = (size == SZ_HALF && adr[0]) || (size == SZ_WORD && adr[1:0] != 2'b00);
  // full-width compare so addresses beyond the array never alias back into it
  assign range_err = adr > (ADDR_W'(DEPTH_BYTES) - ADDR_W'(nbytes));
  assign bad       = (size == 2'b11) || misalign || range_err;
  assign widx      = busy ? idx_q : aidx;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [1:0] sel;
    logic       we;
    logic [7:0] wdat;

    // sel is this lane's byte position within the store data
    assign sel  = 2'(l) - off;
    assign we   = busy || (accept && wren && !bad && ({1'b0, sel} < nbytes));
    assign wdat = busy ? 8'h00 : datain[{sel, 3'b000} +: 8];

    always_ff @(posedge clk) begin
      if (we) mem[widx] <= wdat;
    end

    assign rword[8*l +: 8] = mem[aidx];
  end

  dmem_extend u_extend (
    .word   (rword),
    .off    (off),
    .size   (size),
    .unsgn  (unsgn),
    .result (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdvalid <= 1'b0;
      err     <= 1'b0;
      dataout <= '0;
    end else begin
      rdvalid <= 1'b0;
      err     <= 1'b0;
      if (accept) begin
        if (bad) begin
          err     <= 1'b1;
          dataout <= '0;
        end else if (!wren) begin
          rdvalid <= 1'b1;
          dataout <= ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl at DEPTH_BYTES = 256.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, clear, req, wren, unsgn;
  logic [1:0]  size;
  logic [31:0] adr, datain;
  logic        ready, rdvalid, err, busy;
  logic [31:0] dataout;

  int checks = 0;
  int errors = 0;

  logic        got_rv, got_err;
  logic [31:0] got_dout;

  data_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_BYTES(256)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .req     (req),
    .wren    (wren),
    .size    (size),
    .unsgn   (unsgn),
    .adr     (adr),
    .datain  (datain),
    .ready   (ready),
    .rdvalid (rdvalid),
    .dataout (dataout),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Present one request from a falling edge, hold until ready, sample after the accept edge.
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    req = 1'b1; wren = w; size = sz; unsgn = u; adr = a; datain = d;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL access_timeout adr=%h ready never rose", a);
    end
    @(posedge clk);
    #1;
    got_rv = rdvalid; got_err = err; got_dout = dataout;
    req = 1'b0;
  endtask

  task automatic count_busy(output int n, output logic saw_rv);
    n = 0;
    saw_rv = 1'b0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (rdvalid) saw_rv = 1'b1;
    end
  endtask

  task automatic test_reset();
    int n;
    logic saw;
    rst_n = 1'b1; clear = 1'b0; req = 1'b0; wren = 1'b0;
    size = 2'b00; unsgn = 1'b0; adr = '0; datain = '0;
    #3 rst_n = 1'b0;
    #12;
    checks++;
    if ({ready, rdvalid, err, busy} !== 4'b0001)
      begin errors++; $display("FAIL reset_flags got rdy/rv/err/busy=%b want 0001", {ready, rdvalid, err, busy}); end
    checks++;
    if (dataout !== 32'h0)
      begin errors++; $display("FAIL reset_dataout got %h want 00000000", dataout); end
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n, saw);
    checks++;
    if (n !== 64) begin errors++; $display("FAIL reset_sweep_len got %0d want 64", n); end
    #4;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_sweep got %b want 1", ready); end
    access(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
    checks++;
    if (got_rv !== 1'b1 || got_err !== 1'b0 || got_dout !== 32'h0)
      begin errors++; $display("FAIL load0_after_reset got rv=%b err=%b d=%h want 1 0 00000000", got_rv, got_err, got_dout); end
  endtask

  task automatic test_loads();
    logic [1:0]  t_sz [4] = '{2'b10, 2'b00, 2'b00, 2'b01};
    logic        t_u  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_a  [4] = '{32'h10, 32'h10, 32'h10, 32'h12};
    logic [31:0] t_e  [4] = '{32'h801234F6, 32'hFFFFFFF6, 32'h000000F6, 32'hFFFF8012};
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h801234F6);
    checks++;
    if (got_rv !== 1'b0 || got_err !== 1'b0)
      begin errors++; $display("FAIL store_no_pulse got rv=%b err=%b want 0 0", got_rv, got_err); end
    for (int i = 0; i < 4; i++) begin
      access(1'b0, t_sz[i], t_u[i], t_a[i], 32'h0);
      checks++;
      if (got_rv !== 1'b1 || got_dout !== t_e[i])
        begin errors++; $display("FAIL load_ext_%0d got rv=%b d=%h want 1 %h", i, got_rv, got_dout, t_e[i]); end
    end
  endtask

  task automatic test_byte_store();
    access(1'b1, 2'b00, 1'b0, 32'h13, 32'h777777AB);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++;
    if (got_rv !== 1'b1 || got_dout !== 32'hAB1234F6)
      begin errors++; $display("FAIL byte_store_merge got rv=%b d=%h want 1 ab1234f6", got_rv, got_dout); end
    access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    checks++;
    if (got_dout !== 32'h0)
      begin errors++; $display("FAIL byte_store_neighbour got %h want 00000000", got_dout); end
  endtask

  task automatic test_errors();
    logic [1:0]  t_sz [3] = '{2'b10, 2'b10, 2'b11};
    logic [31:0] t_a  [3] = '{32'h11, 32'h100, 32'h20};
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      access(1'b0, t_sz[i], 1'b0, t_a[i], 32'h0);
      checks++;
      if (got_err !== 1'b1 || got_rv !== 1'b0 || got_dout !== 32'h0)
        begin errors++; $display("FAIL err_load_%0d got err=%b rv=%b d=%h want 1 0 00000000", i, got_err, got_rv, got_dout); end
    end
    access(1'b1, 2'b00, 1'b0, 32'hFF, 32'h0000005A);
    access(1'b1, 2'b01, 1'b0, 32'hFF, 32'h00001234);
    checks++;
    if (got_err !== 1'b1 || got_rv !== 1'b0)
      begin errors++; $display("FAIL err_half_store_ff got err=%b rv=%b want 1 0", got_err, got_rv); end
    access(1'b0, 2'b00, 1'b1, 32'hFF, 32'h0);
    checks++;
    if (got_err !== 1'b0 || got_dout !== 32'h0000005A)
      begin errors++; $display("FAIL err_store_no_write got err=%b d=%h want 0 0000005a", got_err, got_dout); end
    access(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    checks++;
    if (got_err !== 1'b0 || got_rv !== 1'b1 || got_dout !== 32'h5A000000)
      begin errors++; $display("FAIL top_word_in_range got err=%b rv=%b d=%h want 0 1 5a000000", got_err, got_rv, got_dout); end
  endtask

  task automatic test_back_to_back();
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h00000005);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checks++;
    if (got_rv !== 1'b1 || got_dout !== 32'h00000005)
      begin errors++; $display("FAIL back_to_back got rv=%b d=%h want 1 00000005", got_rv, got_dout); end
  endtask

  task automatic test_clear();
    int n;
    logic saw;
    logic [31:0] t_a  [4] = '{32'h10, 32'h20, 32'hFF, 32'h13};
    logic [1:0]  t_sz [4] = '{2'b10, 2'b10, 2'b00, 2'b00};
    @(negedge clk);
    clear = 1'b1; req = 1'b1; wren = 1'b1; size = 2'b10; adr = 32'h30; datain = 32'hDEADBEEF;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL clear_blocks_ready got %b want 0", ready); end
    @(posedge clk);
    #1;
    clear = 1'b0; wren = 1'b0; adr = 32'h10;
    count_busy(n, saw);
    req = 1'b0;
    checks++;
    if (n !== 64) begin errors++; $display("FAIL clear_sweep_len got %0d want 64", n); end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL req_during_sweep got rdvalid=%b want 0", saw); end
    for (int i = 0; i < 4; i++) begin
      access(1'b0, t_sz[i], 1'b1, t_a[i], 32'h0);
      checks++;
      if (got_rv !== 1'b1 || got_dout !== 32'h0)
        begin errors++; $display("FAIL cleared_%0d got rv=%b d=%h want 1 00000000", i, got_rv, got_dout); end
    end
    access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    checks++;
    if (got_dout !== 32'h0)
      begin errors++; $display("FAIL clear_wins_store got %h want 00000000", got_dout); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic saw;
    access(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0)
      begin errors++; $display("FAIL mid_sweep_reset got busy=%b ready=%b want 1 0", busy, ready); end
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n, saw);
    checks++;
    if (n !== 64) begin errors++; $display("FAIL restart_sweep_len got %0d want 64", n); end
    access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    checks++;
    if (got_rv !== 1'b1 || got_dout !== 32'h0)
      begin errors++; $display("FAIL after_restart got rv=%b d=%h want 1 00000000", got_rv, got_dout); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_byte_store();
    test_errors();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised, byte-addressed, little-endian data memory for the single-cycle CPU datapath.
- Successor to the current word-only data memory, adding:
  - byte, half-word and word accesses with sign or zero extension;
  - a registered read with a request/ready handshake;
  - alignment and range error reporting;
  - a hardware clear sequencer that zeroes the array after reset or on command.

Parameters:
- DATA_W, 32: data path width; fixed at 32 for this generation, must be a multiple of 8.
- ADDR_W, 32: address port width.
- DEPTH_BYTES, 256: array size in bytes; a power of two, at least 4.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Clear  in  1  one-cycle pulse that starts a zeroing sweep; ignored while a sweep is running.
- Req  in  1  access request.
- WrEn  in  1  1 = store, 0 = load; sampled with Req.
- Size  in  2  00 byte, 01 half-word, 10 word; 11 is illegal.
- Unsgn  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- Adr  in  ADDR_W  byte address.
- DataIn  in  DATA_W  store data; the low bytes are used per Size.
- Ready  out  1  1 = a request is accepted this cycle.
- RdValid  out  1  one-cycle pulse; DataOut is valid.
- DataOut  out  DATA_W  load result, registered.
- Err  out  1  one-cycle pulse marking a rejected access.
- Busy  out  1  high while a clear sweep is running.

Behaviour:
- Reset values:
  - Ready = 0, RdValid = 0, Err = 0, DataOut = 0, Busy = 1.
  - FSM enters CLEAR with sweep index 0.
  - The array itself is not reset asynchronously.
- FSM states:
  - CLEAR: writes 0 to word index i (4 bytes) each cycle. After index DEPTH_BYTES/4-1 it goes to RUN. Busy = 1, Ready = 0.
  - RUN: Ready = 1, Busy = 0. A Clear pulse moves to CLEAR with index 0 on the next edge. In the cycle Clear is seen, Ready is already 0 and no request is accepted.
- Reset asserted mid-sweep: the sweep restarts at index 0 after release.
- Accept condition: Req && Ready at edge N.
- Checks on an accepted access:
  - Size = 11 is an error.
  - Misaligned is an error: half-word with Adr[0] = 1, or word with Adr[1:0] != 0.
  - Out of range is an error: Adr > DEPTH_BYTES - bytes(Size). Evaluate this at full ADDR_W width so there is no wrap-around.
  - On error: no array write; Err = 1 and DataOut = 0 in cycle N+1. RdValid = 0 for errored loads.
- Store, no error:
  - Bytes Adr .. Adr+bytes-1 are written at edge N.
  - DataIn[7:0] goes to Adr (little-endian).
  - Other bytes are unchanged.
  - No RdValid pulse.
- Load, no error:
  - Bytes are read at edge N and extended per Unsgn/Size.
  - Result is registered into DataOut with RdValid = 1 in cycle N+1. Latency is 1.
- DataOut holds its last value when no load completes.
- Back-to-back:
  - One request is accepted per cycle in RUN.
  - A load accepted the cycle after a store to the same bytes returns the new data.
  - Only one request exists per cycle, so there is no same-cycle read/write conflict.
- A request presented while Ready = 0 is ignored. The requester holds Req until it sees Ready.
- Clear arriving with a request in the same RUN cycle: Clear wins and the request is not accepted.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - state enum {CLEAR, RUN};
  - function bytes_of(size).
- One sub-module, dmem_extend: combinational byte/half select plus sign/zero extension. Instantiated once on the read path.
- The array is inferred as 4 byte-lanes of depth DEPTH_BYTES/4, each with its own write enable, so synthesis maps it to RAM.

Test Plan:
- Reset then wait:
  - Busy stays 1 for exactly 64 cycles (DEPTH_BYTES = 256), then Ready = 1.
  - A load of word at 0x00 returns 0x00000000 with RdValid one cycle later.
- Word store 0x8012_34F6 at 0x10, then loads at 0x10:
  - word → 0x801234F6;
  - byte, Unsgn = 0 → 0xFFFFFFF6;
  - byte, Unsgn = 1 → 0x000000F6;
  - half at 0x12, Unsgn = 0 → 0xFFFF8012.
- Byte store 0xAB at 0x13, then word load at 0x10 → 0xAB1234F6. Neighbouring bytes are unchanged.
- Error cases:
  - word load at 0x11 → Err, RdValid = 0, DataOut = 0;
  - half store at 0xFF → Err, and a later byte load at 0xFF shows the old value;
  - word load at 0x100 → Err;
  - Size = 11 → Err.
- Back-to-back: store word 0x5 at 0x20 in cycle N, load 0x20 in cycle N+1 → 0x00000005 in N+2.
- Clear pulse after stores:
  - Busy for 64 cycles; requests are ignored during the sweep.
  - After the sweep, all earlier stored addresses read 0.
  - Assert Rst_n low at sweep index 30: the sweep restarts and takes a full 64 cycles after release.
